nexus_mult_pipe: RTL

Parametrised pipelined 2-operand multiplier with optional input and output register stages, per-operand signedness, a valid pipeline and an optional accumulate mode. It generalises the fixed 9x9 multiply-with-fabric-registers test cases into one configurable block. The dsp-ff tests use it to check that input, output and control registers are absorbed into the DSP at any width and depth. It also serves as a reusable MAC for designs targeting Nexus DSP slices.

---
 rtl/nexus_mult_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nexus_mult_pipe.sv
// Pipelined A x B multiplier with per-operand signedness, optional input/output
// register stages, a valid pipeline and an optional wrap-around accumulator.
module nexus_mult_pipe #(
  parameter int A_WIDTH   = 9,
  parameter int B_WIDTH   = 9,
  parameter int REG_IN    = 1,
  parameter int REG_OUT   = 1,
  parameter int ACCUM     = 0,
  parameter int ACC_WIDTH = 24,
  localparam int P        = A_WIDTH + B_WIDTH,
  localparam int Z_WIDTH  = (ACCUM != 0) ? ACC_WIDTH : P
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               CE,
  input  logic               IN_VALID,
  input  logic [A_WIDTH-1:0] A,
  input  logic               SIGNEDA,
  input  logic [B_WIDTH-1:0] B,
  input  logic               SIGNEDB,
  input  logic               ACC_CLR,
  output logic               OUT_VALID,
  output logic [Z_WIDTH-1:0] Z,
  output logic               OVF
);

  if (A_WIDTH < 2 || A_WIDTH > 36 || B_WIDTH < 2 || B_WIDTH > 36) begin : g_err_width
    $error("nexus_mult_pipe: operand widths must lie in 2..36");
  end
  if (ACCUM != 0 && REG_OUT == 0) begin : g_err_regout
    $error("nexus_mult_pipe: ACCUM=1 requires REG_OUT=1");
  end
  if (ACCUM != 0 && ACC_WIDTH < P) begin : g_err_accw
    $error("nexus_mult_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end

  logic [A_WIDTH-1:0] stg_a_s;
  logic [B_WIDTH-1:0] stg_b_s;
  logic               stg_sa_s;
  logic               stg_sb_s;
  logic               stg_clr_s;
  logic               stg_v_s;

  if (REG_IN != 0) begin : g_in_reg
    logic [A_WIDTH-1:0] a_r;
    logic [B_WIDTH-1:0] b_r;
    logic               sa_r;
    logic               sb_r;
    logic               clr_r;
    logic               v_r;

    // Input stage: every field loads on CE, valid or not, so the DSP input regs absorb cleanly.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        a_r   <= '0;
        b_r   <= '0;
        sa_r  <= 1'b0;
        sb_r  <= 1'b0;
        clr_r <= 1'b0;
        v_r   <= 1'b0;
      end else if (CE) begin
        a_r   <= A;
        b_r   <= B;
        sa_r  <= SIGNEDA;
        sb_r  <= SIGNEDB;
        clr_r <= ACC_CLR;
        v_r   <= IN_VALID;
      end
    end

    assign stg_a_s   = a_r;
    assign stg_b_s   = b_r;
    assign stg_sa_s  = sa_r;
    assign stg_sb_s  = sb_r;
    assign stg_clr_s = clr_r;
    assign stg_v_s   = v_r;
  end else begin : g_in_bypass
    assign stg_a_s   = A;
    assign stg_b_s   = B;
    assign stg_sa_s  = SIGNEDA;
    assign stg_sb_s  = SIGNEDB;
    assign stg_clr_s = ACC_CLR;
    assign stg_v_s   = IN_VALID;
  end

  logic [P-1:0] a_ext_s;
  logic [P-1:0] b_ext_s;
  logic [P-1:0] prod_s;

  // Extending both operands to P bits first makes the low P bits exact for any signedness mix.
  always_comb begin
    a_ext_s = stg_sa_s ? {{B_WIDTH{stg_a_s[A_WIDTH-1]}}, stg_a_s} : {{B_WIDTH{1'b0}}, stg_a_s};
    b_ext_s = stg_sb_s ? {{A_WIDTH{stg_b_s[B_WIDTH-1]}}, stg_b_s} : {{A_WIDTH{1'b0}}, stg_b_s};
    prod_s  = a_ext_s * b_ext_s;
  end

  if (ACCUM != 0) begin : g_acc
    logic [ACC_WIDTH-1:0] prod_ext_s;
    logic [ACC_WIDTH-1:0] base_s;
    logic [ACC_WIDTH-1:0] sum_s;
    logic                 add_ovf_s;
    logic [ACC_WIDTH-1:0] acc_r;
    logic                 ovf_r;
    logic                 ov_r;

    // A clearing sample zeroes only the accumulator operand, so it can never flag overflow.
    always_comb begin
      prod_ext_s = (stg_sa_s | stg_sb_s) ? ACC_WIDTH'($signed(prod_s)) : ACC_WIDTH'(prod_s);
      base_s     = stg_clr_s ? {ACC_WIDTH{1'b0}} : acc_r;
      sum_s      = base_s + prod_ext_s;
      add_ovf_s  = (base_s[ACC_WIDTH-1] == prod_ext_s[ACC_WIDTH-1]) &&
                   (sum_s[ACC_WIDTH-1] != base_s[ACC_WIDTH-1]);
    end

    // Accumulator and sticky overflow advance only on valid samples.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
        ov_r  <= 1'b0;
      end else if (CE) begin
        ov_r <= stg_v_s;
        if (stg_v_s) begin
          acc_r <= sum_s;
          ovf_r <= (stg_clr_s ? 1'b0 : ovf_r) | add_ovf_s;
        end
      end
    end

    assign Z         = acc_r;
    assign OVF       = ovf_r;
    assign OUT_VALID = ov_r;
  end else if (REG_OUT != 0) begin : g_out_reg
    logic [P-1:0] z_r;
    logic         ov_r;
    logic         unused_clr_s;

    // Product register holds its last value across invalid cycles.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        z_r  <= '0;
        ov_r <= 1'b0;
      end else if (CE) begin
        ov_r <= stg_v_s;
        if (stg_v_s) begin
          z_r <= prod_s;
        end
      end
    end

    assign unused_clr_s = stg_clr_s;
    assign Z            = z_r;
    assign OVF          = 1'b0;
    assign OUT_VALID    = ov_r;
  end else begin : g_out_bypass
    logic unused_clr_s;

    assign unused_clr_s = stg_clr_s;
    assign Z            = prod_s;
    assign OVF          = 1'b0;
    assign OUT_VALID    = stg_v_s;
  end

endmodule
